// File: rtl/dsp_chain_pkg.sv
// Shared defaults and latency helper for the chained sum-of-products datapath.
package dsp_chain_pkg;

  localparam int DEF_AX_W   = 18;
  localparam int DEF_AY_W   = 19;
  localparam int DEF_RES_W  = 37;
  localparam int MAX_STAGES = 16;

  // Operand set in, result_valid out: one product stage, the chain, the output register.
  function automatic int chain_latency(input int num_stages);
    return num_stages + 2;
  endfunction

endpackage

// File: rtl/sop_stage.sv
// One two-product stage: operand skew line, registered ax*ay + bx*by, registered chain add.
module sop_stage
  import dsp_chain_pkg::*;
#(
  parameter int AX_W  = DEF_AX_W,
  parameter int AY_W  = DEF_AY_W,
  parameter int RES_W = DEF_RES_W,
  parameter int SKEW  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AX_W-1:0]  ax,
  input  logic [AX_W-1:0]  bx,
  input  logic [AY_W-1:0]  ay,
  input  logic [AY_W-1:0]  by,
  input  logic [RES_W-1:0] chain_in,
  output logic [RES_W-1:0] chain_out
);

  localparam int OP_W = 2 * AX_W + 2 * AY_W;
  localparam int PW   = AX_W + AY_W;

  logic [OP_W-1:0] opnd_in;
  logic [OP_W-1:0] opnd_d;

  assign opnd_in = {ax, bx, ay, by};

  // Skew line: SKEW register stages so this stage sees the set one cycle after its predecessor
  generate
    if (SKEW == 0) begin : g_noskew
      assign opnd_d = opnd_in;
    end else begin : g_skew
      logic [OP_W-1:0] skew_p [SKEW];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < SKEW; i++) skew_p[i] <= '0;
        end else begin
          skew_p[0] <= opnd_in;
          for (int i = 1; i < SKEW; i++) skew_p[i] <= skew_p[i-1];
        end
      end
      assign opnd_d = skew_p[SKEW-1];
    end
  endgenerate

  logic signed [AX_W-1:0]  ax_d, bx_d;
  logic signed [AY_W-1:0]  ay_d, by_d;
  logic signed [PW-1:0]    prod_a, prod_b;
  logic signed [RES_W-1:0] sop_d, sop_p0, chain_p1;

  assign {ax_d, bx_d, ay_d, by_d} = opnd_d;
  assign prod_a = PW'(ax_d) * PW'(ay_d);
  assign prod_b = PW'(bx_d) * PW'(by_d);
  assign sop_d  = RES_W'(prod_a) + RES_W'(prod_b);

  // p0: product sum register; p1: chain sum register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sop_p0   <= '0;
      chain_p1 <= '0;
    end else begin
      sop_p0   <= sop_d;
      chain_p1 <= chain_in + sop_p0;
    end
  end

  assign chain_out = chain_p1;

endmodule

// File: rtl/dsp_chain_sop_n.sv
// NUM_STAGES skewed sum-of-products stages chained into a wrapping or saturating accumulator.
module dsp_chain_sop_n
  import dsp_chain_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int AX_W       = DEF_AX_W,
  parameter int AY_W       = DEF_AY_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int SATURATE   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       acc_en,
  input  logic [NUM_STAGES*AX_W-1:0] ax,
  input  logic [NUM_STAGES*AX_W-1:0] bx,
  input  logic [NUM_STAGES*AY_W-1:0] ay,
  input  logic [NUM_STAGES*AY_W-1:0] by,
  output logic [RES_W-1:0]           result,
  output logic                       result_valid,
  output logic                       overflow
);

  // Control registers needed to meet the chain output; the output register adds the last cycle.
  localparam int PIPE_D = chain_latency(NUM_STAGES) - 1;

  function automatic logic add_ovf(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b,
                                   input logic [RES_W-1:0] s);
    return (a[RES_W-1] == b[RES_W-1]) && (s[RES_W-1] != a[RES_W-1]);
  endfunction

  function automatic logic [RES_W-1:0] sat_limit(input logic neg);
    return neg ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
  endfunction

  logic [RES_W-1:0] chain [NUM_STAGES];

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [RES_W-1:0] chain_in;
      if (k == 0) begin : g_head
        assign chain_in = '0;
      end else begin : g_link
        assign chain_in = chain[k-1];
      end
      sop_stage #(
        .AX_W (AX_W),
        .AY_W (AY_W),
        .RES_W(RES_W),
        .SKEW (k)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .ax       (ax[k*AX_W +: AX_W]),
        .bx       (bx[k*AX_W +: AX_W]),
        .ay       (ay[k*AY_W +: AY_W]),
        .by       (by[k*AY_W +: AY_W]),
        .chain_in (chain_in),
        .chain_out(chain[k])
      );
    end
  endgenerate

  logic [PIPE_D-1:0] vld_p, acc_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      acc_p <= '0;
    end else begin
      vld_p <= {vld_p[PIPE_D-2:0], in_valid};
      acc_p <= {acc_p[PIPE_D-2:0], acc_en};
    end
  end

  logic signed [RES_W-1:0] sum_in, addend, wrap_sum, next_res;
  logic                    ovf_now;

  assign sum_in   = chain[NUM_STAGES-1];
  assign addend   = acc_p[PIPE_D-1] ? result : '0;
  assign wrap_sum = sum_in + addend;
  assign ovf_now  = add_ovf(sum_in, addend, wrap_sum);
  assign next_res = (SATURATE != 0 && ovf_now) ? sat_limit(sum_in[RES_W-1]) : wrap_sum;

  // Output stage: load or accumulate, overflow sticky across accumulating sets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= vld_p[PIPE_D-1];
      if (vld_p[PIPE_D-1]) begin
        result   <= next_res;
        overflow <= (acc_p[PIPE_D-1] & overflow) | ovf_now;
      end
    end
  end

endmodule
